// File: rtl/load_unit.sv
// load_unit: issues one word-aligned memory read per load and formats the
// returned word into a sign- or zero-extended byte, halfword or word result.
// If no response arrives within TIMEOUT cycles, the load ends with an error
// pulse and the previous result is kept.
module load_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] i2_r_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT);

    state_t      state;
    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic [15:0] tmo_cnt;
    logic        illegal;
    logic        tmo_hit;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] fmt_data;

    assign mem_req_addr = {addr_q[31:2], 2'b00};
    assign tmo_hit      = (TIMEOUT != 0) && (tmo_cnt == TMO_LIMIT);

    // Classify the incoming request: unknown funct3 or misaligned access
    always_comb begin
        illegal = 1'b0;
        case (funct3)
            3'b000, 3'b100: illegal = 1'b0;
            3'b001, 3'b101: illegal = addr[0];
            3'b010:         illegal = (addr[1:0] != 2'b00);
            default:        illegal = 1'b1;
        endcase
    end

    // Select the addressed lane of the read word and extend it
    always_comb begin
        byte_lane = '0;
        case (addr_q[1:0])
            2'd0: byte_lane = mem_resp_data[7:0];
            2'd1: byte_lane = mem_resp_data[15:8];
            2'd2: byte_lane = mem_resp_data[23:16];
            2'd3: byte_lane = mem_resp_data[31:24];
            default: byte_lane = '0;
        endcase
        half_lane = addr_q[1] ? mem_resp_data[31:16] : mem_resp_data[15:0];
        case (funct3_q)
            3'b000:  fmt_data = {{24{byte_lane[7]}}, byte_lane};
            3'b100:  fmt_data = {24'd0, byte_lane};
            3'b001:  fmt_data = {{16{half_lane[15]}}, half_lane};
            3'b101:  fmt_data = {16'd0, half_lane};
            default: fmt_data = mem_resp_data;
        endcase
    end

    // Load FSM; outputs are registered alongside the state they belong to
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            addr_q        <= '0;
            funct3_q      <= '0;
            tmo_cnt       <= '0;
            i2_r_data     <= '0;
            mem_req_valid <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr_q   <= addr;
                        funct3_q <= funct3;
                        tmo_cnt  <= '0;
                        busy     <= 1'b1;
                        if (illegal) begin
                            state <= S_ERR;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state         <= S_REQ;
                            mem_req_valid <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    // handshake takes priority over a coincident timeout
                    if (mem_req_ready) begin
                        state         <= S_WAIT;
                        mem_req_valid <= 1'b0;
                        tmo_cnt       <= tmo_cnt + 16'd1;
                    end else if (tmo_hit) begin
                        state         <= S_ERR;
                        mem_req_valid <= 1'b0;
                        done          <= 1'b1;
                        err           <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                S_WAIT: begin
                    if (mem_resp_valid) begin
                        state     <= S_DONE;
                        i2_r_data <= fmt_data;
                        done      <= 1'b1;
                    end else if (tmo_hit) begin
                        state <= S_ERR;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                S_DONE, S_ERR: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state         <= S_IDLE;
                    busy          <= 1'b0;
                    mem_req_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_unit.sv
// Scoreboard bench for load_unit: the driver pushes the expected completion
// (err flag, result, cycle) per load; a monitor pops on every done pulse.
module tb_load_unit;

    localparam int unsigned T = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = '0;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] i2_r_data;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    logic [31:0] last_data = '0;

    typedef struct {
        logic        e;
        logic [31:0] d;
        int unsigned c;
    } exp_t;

    exp_t sb[$];

    load_unit #(.TIMEOUT(T)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .funct3(funct3),
        .addr(addr),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data),
        .busy(busy),
        .done(done),
        .err(err),
        .i2_r_data(i2_r_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic is_illegal(input logic [2:0] f, input logic [31:0] a);
        if (f == 3'd3 || f == 3'd6 || f == 3'd7) return 1'b1;
        if ((f == 3'd1 || f == 3'd5) && (a % 2) == 1) return 1'b1;
        if (f == 3'd2 && (a % 4) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] fmt_ref(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] v;
        int unsigned k;
        if (f == 3'd0 || f == 3'd4) begin
            k = a % 4;
            v = (d >> (8 * k)) & 32'hFF;
            if (f == 3'd0 && v >= 32'h80) v = v + 32'hFFFFFF00;
        end else if (f == 3'd1 || f == 3'd5) begin
            k = (a % 4) / 2;
            v = (d >> (16 * k)) & 32'hFFFF;
            if (f == 3'd1 && v >= 32'h8000) v = v + 32'hFFFF0000;
        end else begin
            v = d;
        end
        return v;
    endfunction

    // One load: r = cycles ready stays low in REQ, s = cycles response stays
    // low in WAIT; chaos adds ignored start/ready/response noise.
    task automatic do_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                           input int unsigned r, input int unsigned s, input logic chaos);
        logic        ill;
        logic        in_req;
        int unsigned endj;
        int unsigned req_last;
        exp_t        x;
        ill = is_illegal(f, a);
        if (ill) begin
            endj = 0; x.e = 1'b1;
        end else if (T != 0 && r > T) begin
            endj = T + 1; x.e = 1'b1;
        end else if (T != 0 && r < T && r + 1 + s > T) begin
            endj = T + 1; x.e = 1'b1;
        end else begin
            endj = r + s + 2; x.e = 1'b0;
        end
        req_last = (T != 0 && r > T) ? T : r;
        x.d = x.e ? last_data : fmt_ref(f, a, d);
        x.c = cyc + 1 + endj;
        sb.push_back(x);
        last_data = x.d;

        start = 1'b1; funct3 = f; addr = a;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = d;
        for (int unsigned j = 0; j <= endj; j++) begin
            @(negedge clk);
            in_req = !ill && (j <= req_last);
            check("busy", busy, 1);
            check("req_valid", mem_req_valid, in_req);
            if (in_req) check("req_addr", mem_req_addr, a & 32'hFFFFFFFC);
            start  = chaos ? 1'($urandom_range(0, 1)) : 1'b0;
            funct3 = 3'($urandom);
            addr   = $urandom;
            mem_req_ready  = (j == r) || (chaos && j > r && $urandom_range(0, 1) == 1);
            mem_resp_valid = (j == r + 1 + s) || (chaos && j <= r && $urandom_range(0, 1) == 1);
        end
        start = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    endtask

    // Monitor: every done pulse must match the oldest outstanding load
    always @(negedge clk) begin
        if (!rst) begin
            if (err && !done) begin
                errors++; checks++;
                $display("FAIL err_without_done: got err=1 done=0 expected err=0");
            end
            if (done) begin
                if (sb.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL unexpected_done: got done=1 expected no completion (cycle %0d)", cyc);
                end else begin
                    exp_t x;
                    x = sb.pop_front();
                    check("done_err", err, x.e);
                    check("result", i2_r_data, x.d);
                    check("done_cycle", cyc, x.c);
                end
            end
        end
    end

    initial begin
        #4_000_000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  f;
        int unsigned r;
        int unsigned s;

        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_req_valid", mem_req_valid, 0);
        check("rst_data", i2_r_data, 0);
        check("rst_req_addr", mem_req_addr, 0);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        // first cycle after reset release
        do_load(3'd0, 32'h1003, 32'h80FF0011, 0, 0, 1'b0);
        @(negedge clk); do_load(3'd5, 32'h2002, 32'hBEEF1234, 0, 0, 1'b0);
        @(negedge clk); do_load(3'd1, 32'h2002, 32'hBEEF1234, 0, 0, 1'b0);
        @(negedge clk); do_load(3'd2, 32'h3001, 32'h55555555, 0, 0, 1'b0);
        @(negedge clk); do_load(3'd2, 32'h4000, 32'h12345678, 4, 2, 1'b1);
        @(negedge clk); do_load(3'd2, 32'h4004, 32'hDEADBEEF, 0, 20, 1'b1);
        @(negedge clk); do_load(3'd4, 32'h4005, 32'hDEADBEEF, 20, 0, 1'b1);
        @(negedge clk); do_load(3'd4, 32'h4006, 32'h00A10000, T, 0, 1'b0);
        @(negedge clk); do_load(3'd1, 32'h4002, 32'h9ABC0000, 2, T - 3, 1'b0);
        @(negedge clk); do_load(3'd6, 32'h4000, 32'h1, 0, 0, 1'b0);

        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            f = 3'($urandom_range(0, 7));
            r = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 12) : $urandom_range(0, 3);
            s = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 12) : $urandom_range(0, 3);
            do_load(f, $urandom, $urandom, r, s, 1'($urandom_range(0, 1)));
        end

        // reset while waiting for the response
        @(negedge clk); do_load(3'd2, 32'h6000, 32'hA5A5A5A5, 0, 0, 1'b0);
        @(negedge clk);
        start = 1'b1; funct3 = 3'd2; addr = 32'h5000; mem_resp_data = 32'hCAFEF00D;
        @(negedge clk);
        start = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        check("wait_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_req_valid", mem_req_valid, 0);
        check("midrst_done", done, 0);
        check("midrst_data", i2_r_data, 0);
        #1;
        rst = 1'b0;
        last_data = '0;
        @(negedge clk);
        mem_resp_valid = 1'b1;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        check("late_resp_busy", busy, 0);
        check("late_resp_data", i2_r_data, 0);
        do_load(3'd4, 32'h7001, 32'h0000C300, 1, 1, 1'b0);

        repeat (4) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_unit.md
LOAD_UNIT -- requirements
Module: load_unit

Interface
- REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the cycle limit from entering REQ to a response; 0 disables timeout; legal range 0..65535.
- REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
- REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
- REQ-004 SHALL have port start  input  1  load request from the execute stage; sampled only in IDLE.
- REQ-005 SHALL have port funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- REQ-006 SHALL have port addr  input  32  byte address of the load (ALU result).
- REQ-007 SHALL have port mem_req_valid  output  1  memory read request valid.
- REQ-008 SHALL have port mem_req_ready  input  1  memory accepts the request.
- REQ-009 SHALL have port mem_req_addr  output  32  word-aligned request address: latched addr with bits [1:0] forced to 0.
- REQ-010 SHALL have port mem_resp_valid  input  1  read data valid.
- REQ-011 SHALL have port mem_resp_data  input  32  little-endian read word.
- REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.
- REQ-013 SHALL have port done  output  1  one-cycle completion pulse.
- REQ-014 SHALL have port err  output  1  one-cycle error pulse, coincident with done.
- REQ-015 SHALL have port i2_r_data  output  32  formatted load result, held until the next successful load; feeds the writeback result select.

Function
- REQ-016 SHALL implement states IDLE, REQ, WAIT, DONE, ERR.
- REQ-017 In IDLE with start=1, the block SHALL latch addr and funct3 and go to ERR if the request is illegal, otherwise to REQ. Illegal means any of:
  - funct3 is 011, 110 or 111;
  - LH/LHU with addr[0]=1;
  - LW with addr[1:0]≠00.
- REQ-018 start SHALL be ignored in every state other than IDLE.
- REQ-019 In REQ, mem_req_valid SHALL be 1.
- REQ-020 In REQ, mem_req_addr SHALL hold stable until mem_req_ready=1.
- REQ-021 In REQ, mem_req_ready=1 SHALL cause a transition to WAIT.
- REQ-022 mem_req_valid SHALL be 0 in all states except REQ.
- REQ-023 In WAIT, mem_resp_valid=1 SHALL load the formatted data into i2_r_data and cause a transition to DONE.
- REQ-024 mem_resp_valid SHALL be ignored outside WAIT.
- REQ-025 Formatting SHALL use byte lane k = mem_resp_data[8k+7:8k], with k = addr[1:0] for bytes and k = {addr[1],0} for halfwords, as follows:
  - LB/LH: sign-extend the selected byte/halfword;
  - LBU/LHU: zero-extend it;
  - LW: pass the full word.
- REQ-026 A 16-bit timeout counter SHALL clear on entry to REQ and increment each cycle in REQ or WAIT.
- REQ-027 When TIMEOUT≠0 and the counter equals TIMEOUT with no accepting handshake that cycle, the block SHALL go to ERR.
- REQ-028 A handshake in the same cycle as the timeout SHALL win.
- REQ-029 DONE SHALL assert done=1 and err=0 for exactly one cycle, then go to IDLE.
- REQ-030 ERR SHALL assert done=1 and err=1 for exactly one cycle, then go to IDLE, leaving i2_r_data unchanged.
- REQ-031 Minimum latency with ready and response each arriving in the first possible cycle SHALL be 3 cycles:
  - start at edge 0 → REQ;
  - ready → WAIT at edge 1;
  - response → DONE at edge 2;
  - done high in the following cycle.
- REQ-032 Back-to-back loads SHALL be possible: start may be asserted in the cycle after done, since the FSM is back in IDLE.

Reset
- REQ-033 rst=1 SHALL immediately force IDLE and clear i2_r_data, the timeout counter and the latched addr/funct3 to 0.
- REQ-034 rst=1 SHALL immediately drive mem_req_valid, busy, done and err to 0.
- REQ-035 Reset asserted mid-operation SHALL abandon the load with no done or err pulse.
- REQ-036 A memory response arriving after a mid-operation reset SHALL be ignored.
- REQ-037 The block SHALL accept start in the first cycle after rst deasserts.

Verification
- REQ-038 LB, addr=0x1003, ready and response immediate, data=0x80FF0011 → i2_r_data=0xFFFFFF80, done pulse 3 cycles after start, err=0.
- REQ-039 LHU, addr=0x2002, data=0xBEEF1234 → i2_r_data=0x0000BEEF; LH at the same address and data → 0xFFFFBEEF.
- REQ-040 LW, addr=0x3001 → ERR next cycle, done=err=1, mem_req_valid never asserted, i2_r_data unchanged.
- REQ-041 mem_req_ready held low for 4 cycles, then response after 2 more cycles, data=0x12345678 → mem_req_addr stable throughout, i2_r_data=0x12345678.
- REQ-042 TIMEOUT=8, ready given, no response → err and done pulse when the counter reaches 8; start pulses during busy have no effect.
- REQ-043 rst asserted while in WAIT, response 1 cycle later → no done, i2_r_data=0, busy=0.
